// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
//   Bundles the display driver's data inputs and segment outputs.
//   master : the producer side (clock/time-setting block or testbench)
//            drives en/data/blink_mask and observes the segment buses.
//   slave  : the display driver itself.
//   Signals:
//     en          1 = display on, 0 = all outputs blanked
//     data        32-bit packed digit nibbles, data[31:28] = pos 7
//     blink_mask  bit p = 1 -> digit at pos p blinks
//     seg_data    left group segments (pos 7..4), {a..g,dp}
//     seg_data2   right group segments (pos 3..0), {a..g,dp}
//     seg_cs      digit enables, bit p = pos p
interface seg_scan_display_if;
    logic        en;
    logic [31:0] data;
    logic [7:0]  blink_mask;
    logic [7:0]  seg_data;
    logic [7:0]  seg_data2;
    logic [7:0]  seg_cs;

    modport master (output en, data, blink_mask,
                    input  seg_data, seg_data2, seg_cs);
    modport slave  (input  en, data, blink_mask,
                    output seg_data, seg_data2, seg_cs);
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed driver for an 8-digit, two-bus 7-segment display.
//   Four slots per frame; slot k lights pos 7-k on seg_data and pos 3-k on
//   seg_data2. The digit word and blink mask are latched once per frame so
//   a frame never mixes old and new digits.
//   Ports:
//     i_clk   system clock
//     i_rst   asynchronous, active-low reset
//     bus     seg_scan_display_if.slave (en, data, blink_mask in;
//             seg_data, seg_data2, seg_cs out; all outputs registered)
module seg_scan_display #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg_scan_display_if.slave  bus
);
    localparam int SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_DIV - 1);

    logic [SCW-1:0] r_scan_cnt;
    logic [BKW-1:0] r_blink_cnt;
    logic [1:0]     r_idx;
    logic           r_phase;
    logic [31:0]    r_shadow;
    logic [7:0]     r_mask_sh;
    logic [7:0]     r_seg_data;
    logic [7:0]     r_seg_data2;
    logic [7:0]     r_seg_cs;

    logic           w_tick;
    logic           w_blink_tc;
    logic [2:0]     w_pos_l;
    logic [2:0]     w_pos_r;
    logic [7:0]     w_cs;
    logic [7:0]     w_seg_l;
    logic [7:0]     w_seg_r;

    // Segment encoding {a,b,c,d,e,f,g,dp}; A..E blank, F is a dash.
    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'h0:    dec = 8'hFC;
            4'h1:    dec = 8'h60;
            4'h2:    dec = 8'hDA;
            4'h3:    dec = 8'hF2;
            4'h4:    dec = 8'h66;
            4'h5:    dec = 8'hB6;
            4'h6:    dec = 8'hBE;
            4'h7:    dec = 8'hE0;
            4'h8:    dec = 8'hFE;
            4'h9:    dec = 8'hF6;
            4'hF:    dec = 8'h02;
            default: dec = 8'h00;
        endcase
    endfunction

    assign w_tick     = (r_scan_cnt  == SCAN_LAST);
    assign w_blink_tc = (r_blink_cnt == BLINK_LAST);

    // 3-k over two bits is just ~k; the left group sits 4 positions higher.
    assign w_pos_r = {1'b0, ~r_idx};
    assign w_pos_l = {1'b1, ~r_idx};

    always_comb begin
        w_cs    = (8'h01 << w_pos_l) | (8'h01 << w_pos_r);
        w_seg_l = dec(r_shadow[{w_pos_l, 2'b00} +: 4]);
        w_seg_r = dec(r_shadow[{w_pos_r, 2'b00} +: 4]);
        // Blanked digits keep their enable; only the segments go dark.
        if (r_phase && r_mask_sh[w_pos_l]) w_seg_l = 8'h00;
        if (r_phase && r_mask_sh[w_pos_r]) w_seg_r = 8'h00;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_idx       <= 2'd0;
            r_phase     <= 1'b0;
            r_shadow    <= 32'hFFFF_FFFF;
            r_mask_sh   <= 8'h00;
            r_seg_data  <= 8'h00;
            r_seg_data2 <= 8'h00;
            r_seg_cs    <= 8'h00;
        end else begin
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + SCW'(1);
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
                // Latch on the last slot's tick so slot 0 of the new frame
                // already shows the new word.
                if (r_idx == 2'd3) begin
                    r_shadow  <= bus.data;
                    r_mask_sh <= bus.blink_mask;
                end
            end

            r_blink_cnt <= w_blink_tc ? '0 : r_blink_cnt + BKW'(1);
            if (w_blink_tc) r_phase <= ~r_phase;

            // Output stage sees the state settled at the previous edge,
            // giving one cycle of latency after any slot/phase change.
            if (bus.en) begin
                r_seg_cs    <= w_cs;
                r_seg_data  <= w_seg_l;
                r_seg_data2 <= w_seg_r;
            end else begin
                r_seg_cs    <= 8'h00;
                r_seg_data  <= 8'h00;
                r_seg_data2 <= 8'h00;
            end
        end
    end

    assign bus.seg_data  = r_seg_data;
    assign bus.seg_data2 = r_seg_data2;
    assign bus.seg_cs    = r_seg_cs;
endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
    localparam int SD = 4;
    localparam int BD = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    seg_scan_display_if bus ();

    seg_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: t = clock edges since reset release. Slot, phase and
    // frame boundaries follow from integer division of t; outputs after edge
    // t+1 reflect the state reached after edge t.
    int          t;
    logic [31:0] m_sh;
    logic [7:0]  m_mk;
    logic [7:0]  e_cs, e_d, e_d2;
    bit          m_valid = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_sh = 32'hFFFF_FFFF; m_mk = 8'h00;
            e_cs = 8'h00; e_d = 8'h00; e_d2 = 8'h00;
            m_valid = 1;
        end else begin
            int k, ph, pl, pr;
            k  = (t / SD) % 4;
            ph = (t / BD) % 2;
            pl = 7 - k;
            pr = 3 - k;
            if (bus.en) begin
                e_cs = (8'h01 << pl) | (8'h01 << pr);
                e_d  = (ph == 1 && m_mk[pl]) ? 8'h00 : seg_tab[m_sh[pl*4 +: 4]];
                e_d2 = (ph == 1 && m_mk[pr]) ? 8'h00 : seg_tab[m_sh[pr*4 +: 4]];
            end else begin
                e_cs = 8'h00; e_d = 8'h00; e_d2 = 8'h00;
            end
            t++;
            if (t % (4 * SD) == 0) begin
                m_sh = bus.data;
                m_mk = bus.blink_mask;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_cs",    bus.seg_cs,    e_cs);
            chk("model_data",  bus.seg_data,  e_d);
            chk("model_data2", bus.seg_data2, e_d2);
        end
    end

    task automatic lit(input string nm, input logic [7:0] cs, input logic [7:0] d, input logic [7:0] d2);
        chk({nm, "_cs"},    bus.seg_cs,    cs);
        chk({nm, "_data"},  bus.seg_data,  d);
        chk({nm, "_data2"}, bus.seg_data2, d2);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.data = 32'h12F3_4F56;
        bus.blink_mask = 8'h00;
        repeat (3) @(negedge clk);
        lit("reset", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        @(negedge clk);                      // edge 1: slot 0, dashes
        lit("first_slot", 8'h88, 8'h02, 8'h02);
        repeat (16) @(negedge clk);          // edge 17: new frame slot 0
        lit("frame_s0", 8'h88, 8'h60, 8'h66);
        repeat (4) @(negedge clk);
        lit("frame_s1", 8'h44, 8'hDA, 8'h02);
        repeat (4) @(negedge clk);
        lit("frame_s2", 8'h22, 8'h02, 8'hB6);
        repeat (4) @(negedge clk);
        lit("frame_s3", 8'h11, 8'hF2, 8'hBE);

        repeat (8) @(negedge clk);           // edge 37: idx = 1
        bus.data = 32'h0000_0000;
        repeat (8) @(negedge clk);           // edge 45: still old frame
        lit("midframe_old", 8'h11, 8'hF2, 8'hBE);
        repeat (4) @(negedge clk);           // edge 49: new frame
        lit("newframe_zero", 8'h88, 8'hFC, 8'hFC);

        bus.data = 32'h12F3_4F56;
        bus.blink_mask = 8'h03;
        repeat (28) @(negedge clk);          // edge 77: slot 3, phase 1
        lit("blink_off", 8'h11, 8'hF2, 8'h00);
        repeat (64) @(negedge clk);          // edge 141: slot 3, phase 0
        lit("blink_on", 8'h11, 8'hF2, 8'hBE);

        bus.en = 1'b0;
        @(negedge clk);                      // edge 142
        lit("en_off", 8'h00, 8'h00, 8'h00);
        repeat (4) @(negedge clk);           // edge 146
        bus.en = 1'b1;
        @(negedge clk);                      // edge 147: slot 0
        lit("en_resume", 8'h88, 8'h60, 8'h66);

        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(7) == 0)  bus.data = $urandom;
            if ($urandom_range(15) == 0) bus.blink_mask = 8'($urandom);
            if ($urandom_range(19) == 0) bus.en = ~bus.en;
        end

        bus.en = 1'b1;
        bus.blink_mask = 8'h00;
        bus.data = 32'hABCD_EABC;
        repeat (40) @(negedge clk);

        #2 rst_n = 1'b0;
        #1 lit("async_reset", 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lit("restart", 8'h88, 8'h02, 8'h02);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
